avalon_master: RTL
==================

Name: avalon_master

Overview:
- Avalon-MM initiator that drives the accelerator's Avalon slave interface (write, read, beginbursttransfer, burstcount, address, writedata, waitrequest, readdatavalid, writeresponsevalid, response).
- Accepts single write, single read and burst-write commands from a host-side command port.
- Sequences each command on the bus and returns read data and a completion status.
- Sits between the host or DMA logic and the accelerator, and is reused as the bus-functional driver in system-level benches.

Parameters:
ADDR_W, 11, address width
DATA_W, 32, data width
MAX_BURST, 16, largest legal burst length in beats (must be ≤ 1023)
TIMEOUT, 255, cycles allowed for a response/readdatavalid before the command is aborted

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted on a clk edge where cmd_valid && cmd_ready
cmd_op  in  2  00 single write, 01 single read, 10 burst write, 11 illegal
cmd_addr  in  ADDR_W  target address
cmd_len  in  10  burst beat count (ignored for single ops)
cmd_wdata  in  DATA_W  single-write data, latched at accept
wr_data  in  DATA_W  burst beat data stream
wr_valid  in  1  wr_data valid
wr_ready  out  1  beat consumed this cycle
rd_data  out  DATA_W  read result, registered
rd_valid  out  1  one-cycle pulse with rd_data
done  out  1  one-cycle pulse at command completion
err  out  1  valid with done: 1 = failed
write  out  1  Avalon write
read  out  1  Avalon read
beginbursttransfer  out  1  Avalon burst start
burstcount  out  10  Avalon burst length
address  out  ADDR_W  Avalon address
writedata  out  DATA_W  Avalon write data
readdata  in  DATA_W  Avalon read data
waitrequest  in  1  slave stall
readdatavalid  in  1  read data strobe
writeresponsevalid  in  1  write response strobe
response  in  2  00 OKAY; any other value is an error

Behaviour:
- Reset (asynchronous, any time, including mid-burst): all outputs 0 except cmd_ready = 1; state IDLE; counters cleared; the in-flight command is dropped with no done.
- All bus outputs are registered.
- States: IDLE, WR, WR_RESP, RD, RD_WAIT, BURST, BURST_RESP, FINISH.
- IDLE, on accept:
  - op 00 → WR; write=1, address, writedata driven the next cycle.
  - op 01 → RD; read=1, address driven.
  - op 10 with 1 ≤ cmd_len ≤ MAX_BURST → BURST.
  - op 11, cmd_len = 0, or cmd_len > MAX_BURST → FINISH with err=1 and no bus activity.
- WR/RD: signals are held stable while waitrequest = 1. A transfer completes on the edge where waitrequest = 0. On that edge write/read, address and writedata drop to 0, and the state moves to WR_RESP or RD_WAIT.
- WR_RESP/BURST_RESP: wait for writeresponsevalid, then capture response and go to FINISH.
- RD_WAIT: wait for readdatavalid; rd_data ← readdata, rd_valid pulses with done; err = (response ≠ 00).
- Timeout: a counter runs in every *_RESP/RD_WAIT state. It is cleared on entry. When it reaches TIMEOUT → FINISH with err=1. A late strobe arriving after that is ignored.
- BURST:
  - One-entry holding register feeds writedata.
  - wr_ready = wr_valid && beats_left > 0 && (holding empty || beat accepted this cycle). Accepted means write && !waitrequest.
  - write = 1 only while the holding register is full. With wr_valid low, write drops and idle cycles are inserted.
  - First beat: beginbursttransfer = 1, burstcount = cmd_len, address = cmd_addr. beginbursttransfer lasts exactly one cycle even if waitrequest stalls. burstcount and address are 0 on later beats.
  - beats_left decrements on each accepted beat. At 0, write drops and the state moves to BURST_RESP, which expects exactly one writeresponsevalid.
- FINISH: done=1 for one cycle, then IDLE; cmd_ready reasserts the cycle after done.
- Simultaneous events: waitrequest low together with a strobe already asserted is legal; a strobe is only sampled in its own wait state. readdatavalid/writeresponsevalid in IDLE are ignored.

Test Plan:
- Reset mid-burst (n_rst low after beat 3 of 10) → write, beginbursttransfer, done = 0 immediately, cmd_ready = 1; no further beats after release.
- Single write 0x001 ← 0x00000008, waitrequest high 2 cycles, response 00 one cycle later → write held 3 cycles with stable address/data; done=1, err=0.
- Single read 0x001, readdatavalid 3 cycles after acceptance with readdata 0x00000008 → rd_valid=1, rd_data=0x00000008, err=0.
- Burst write at 0x000, cmd_len=10, wr_data = 2*i for i = 0..9, waitrequest toggling every other cycle, wr_valid gap at beat 5 → exactly 10 accepted beats in order 0,2,…,18; beginbursttransfer one cycle; burstcount=10 on first beat only.
- Write with response=2'b10 → done with err=1; read where readdatavalid never arrives → done, err=1 at TIMEOUT+1 cycles.
- cmd_len=0, cmd_len=17 and cmd_op=11 → done, err=1, with no write/read ever asserted.

Source files
------------

// File: rtl/avalon_master.sv
// ---------------------------------------------------------------------------
// avalon_master
//   Avalon-MM initiator driving the accelerator's slave port. A host-side
//   command port delivers single writes, single reads and burst writes; each
//   command is sequenced on the bus and finishes with a one-cycle done pulse
//   (plus err, and rd_valid/rd_data for reads).
//
// Ports
//   clk, n_rst           : clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (ready only while idle)
//   cmd_op/addr/len/wdata: command fields (op 00 wr, 01 rd, 10 burst, 11 bad)
//   wr_data/wr_valid/
//   wr_ready             : burst beat stream, beat consumed when wr_ready=1
//   rd_data/rd_valid     : registered read result, pulses with done
//   done/err             : completion pulse and failure flag
//   write/read/beginbursttransfer/burstcount/address/writedata : Avalon outs
//   readdata/waitrequest/readdatavalid/writeresponsevalid/response: Avalon ins
// ---------------------------------------------------------------------------
module avalon_master #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [9:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              write,
  output logic              read,
  output logic              beginbursttransfer,
  output logic [9:0]        burstcount,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              waitrequest,
  input  logic              readdatavalid,
  input  logic              writeresponsevalid,
  input  logic [1:0]        response
);

  localparam int               CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [9:0]       LEN_MAX = 10'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD, RD_WAIT, BURST, BURST_RESP, FINISH
  } state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic                read_q, read_d;
  logic                bbt_q, bbt_d;
  logic [9:0]          burstcount_q, burstcount_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic [DATA_W-1:0]   rdData_q, rdData_d;
  logic                rdValid_q, rdValid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [9:0]          beatsLeft_q, beatsLeft_d;
  logic [9:0]          fetchLeft_q, fetchLeft_d;
  logic                firstPending_q, firstPending_d;
  logic [9:0]          burstLen_q, burstLen_d;
  logic [ADDR_W-1:0]   burstAddr_q, burstAddr_d;
  logic                accepted;
  logic                wrReady;

  // State and every bus-facing output live in flops so the Avalon side is
  // glitch-free; reset drops any in-flight command without a done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      write_q        <= 1'b0;
      read_q         <= 1'b0;
      bbt_q          <= 1'b0;
      burstcount_q   <= '0;
      address_q      <= '0;
      writedata_q    <= '0;
      rdData_q       <= '0;
      rdValid_q      <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      cnt_q          <= '0;
      beatsLeft_q    <= '0;
      fetchLeft_q    <= '0;
      firstPending_q <= 1'b0;
      burstLen_q     <= '0;
      burstAddr_q    <= '0;
    end else begin
      state_q        <= state_d;
      write_q        <= write_d;
      read_q         <= read_d;
      bbt_q          <= bbt_d;
      burstcount_q   <= burstcount_d;
      address_q      <= address_d;
      writedata_q    <= writedata_d;
      rdData_q       <= rdData_d;
      rdValid_q      <= rdValid_d;
      done_q         <= done_d;
      err_q          <= err_d;
      cnt_q          <= cnt_d;
      beatsLeft_q    <= beatsLeft_d;
      fetchLeft_q    <= fetchLeft_d;
      firstPending_q <= firstPending_d;
      burstLen_q     <= burstLen_d;
      burstAddr_q    <= burstAddr_d;
    end
  end

  // During a burst, writedata_q is the one-entry holding register and write_q
  // is its full flag. fetchLeft counts beats still to pull from the stream and
  // beatsLeft counts beats still to be accepted by the slave; they differ by
  // the beat sitting in the holding register, which stops an extra beat from
  // being pulled when the last one is accepted.
  always_comb begin
    state_d        = state_q;
    write_d        = write_q;
    read_d         = read_q;
    bbt_d          = 1'b0;
    burstcount_d   = burstcount_q;
    address_d      = address_q;
    writedata_d    = writedata_q;
    rdData_d       = rdData_q;
    rdValid_d      = 1'b0;
    done_d         = 1'b0;
    err_d          = 1'b0;
    cnt_d          = cnt_q;
    beatsLeft_d    = beatsLeft_q;
    fetchLeft_d    = fetchLeft_q;
    firstPending_d = firstPending_q;
    burstLen_d     = burstLen_q;
    burstAddr_d    = burstAddr_q;

    accepted = write_q && !waitrequest;
    wrReady  = (state_q == BURST) && wr_valid && (fetchLeft_q != 10'd0) &&
               (!write_q || accepted);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00: begin
              state_d     = WR;
              write_d     = 1'b1;
              address_d   = cmd_addr;
              writedata_d = cmd_wdata;
            end
            2'b01: begin
              state_d   = RD;
              read_d    = 1'b1;
              address_d = cmd_addr;
            end
            2'b10: begin
              if (cmd_len != 10'd0 && cmd_len <= LEN_MAX) begin
                state_d        = BURST;
                beatsLeft_d    = cmd_len;
                fetchLeft_d    = cmd_len;
                firstPending_d = 1'b1;
                burstLen_d     = cmd_len;
                burstAddr_d    = cmd_addr;
              end else begin
                state_d = FINISH;
                done_d  = 1'b1;
                err_d   = 1'b1;
              end
            end
            default: begin
              state_d = FINISH;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      WR, RD: begin
        if (!waitrequest) begin
          write_d     = 1'b0;
          read_d      = 1'b0;
          address_d   = '0;
          writedata_d = '0;
          cnt_d       = '0;
          state_d     = (state_q == WR) ? WR_RESP : RD_WAIT;
        end
      end
      WR_RESP, BURST_RESP: begin
        if (writeresponsevalid) begin
          state_d = FINISH;
          done_d  = 1'b1;
          err_d   = (response != 2'b00);
        end else if (cnt_q == CNT_MAX) begin
          state_d = FINISH;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RD_WAIT: begin
        if (readdatavalid) begin
          state_d   = FINISH;
          done_d    = 1'b1;
          err_d     = (response != 2'b00);
          rdData_d  = readdata;
          rdValid_d = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = FINISH;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BURST: begin
        // Header fields accompany only the first beat and clear once it is
        // taken; a refill in the same cycle overrides the drop of write.
        if (accepted) begin
          beatsLeft_d  = beatsLeft_q - 10'd1;
          burstcount_d = '0;
          address_d    = '0;
          write_d      = 1'b0;
          writedata_d  = '0;
        end
        if (wrReady) begin
          write_d     = 1'b1;
          writedata_d = wr_data;
          fetchLeft_d = fetchLeft_q - 10'd1;
          if (firstPending_q) begin
            bbt_d          = 1'b1;
            burstcount_d   = burstLen_q;
            address_d      = burstAddr_q;
            firstPending_d = 1'b0;
          end
        end
        if (accepted && beatsLeft_q == 10'd1) begin
          state_d = BURST_RESP;
          cnt_d   = '0;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready          = (state_q == IDLE);
  assign wr_ready           = wrReady;
  assign rd_data            = rdData_q;
  assign rd_valid           = rdValid_q;
  assign done               = done_q;
  assign err                = err_q;
  assign write              = write_q;
  assign read               = read_q;
  assign beginbursttransfer = bbt_q;
  assign burstcount         = burstcount_q;
  assign address            = address_q;
  assign writedata          = writedata_q;

endmodule
